// File: rtl/rambus_pkg.sv
// Shared definitions for OpenRAM bus initiators: bus widths and the
// read-engine state set.
package rambus_pkg;

  localparam int unsigned RAMBUS_AW = 10;
  localparam int unsigned RAMBUS_DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } rambus_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with register-array storage, occupancy count and a
// synchronous flush that empties it in one cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; flush overrides any push/pop.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rambus_stream_reader.sv
// Wishbone read engine: fetches a run of words from shared RAM with single
// classic reads, buffers them and streams them out on valid/ready.
module rambus_stream_reader
  import rambus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start,
  input  logic                 abort,
  input  logic [RAMBUS_AW-1:0] base_adr,
  input  logic [RAMBUS_AW-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 rambus_wb_clk_o,
  output logic                 rambus_wb_rst_o,
  output logic                 rambus_wb_cyc_o,
  output logic                 rambus_wb_stb_o,
  output logic                 rambus_wb_we_o,
  output logic [3:0]           rambus_wb_sel_o,
  output logic [RAMBUS_DW-1:0] rambus_wb_dat_o,
  output logic [RAMBUS_AW-1:0] rambus_wb_adr_o,
  input  logic                 rambus_wb_ack_i,
  input  logic [RAMBUS_DW-1:0] rambus_wb_dat_i,
  output logic [RAMBUS_DW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  rambus_state_e        state_q, state_d;
  logic [RAMBUS_AW-1:0] adr_q, adr_d;
  logic [RAMBUS_AW-1:0] rem_q, rem_d;
  logic [7:0]           tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic                 abt_q, abt_d;
  logic                 cyc;
  logic                 fifo_push, fifo_flush, fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;

  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = wb_rst_i;
  assign rambus_wb_cyc_o = cyc;
  assign rambus_wb_stb_o = cyc;
  assign rambus_wb_we_o  = 1'b0;
  assign rambus_wb_sel_o = 4'hF;
  assign rambus_wb_dat_o = '0;
  assign rambus_wb_adr_o = adr_q;
  assign busy            = (state_q != ST_IDLE);
  assign out_valid       = !fifo_empty;

  sync_fifo #(
    .WIDTH (RAMBUS_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (rambus_wb_dat_i),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state, counters and bus/handshake outputs.
  // abort is latched once seen so a short pulse still ends the run at the
  // next safe point instead of being lost while a bus cycle completes.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    rem_d      = rem_q;
    tmo_d      = '0;
    err_d      = err_q;
    abt_d      = abt_q;
    cyc        = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        abt_d = 1'b0;
        if (start) begin
          if (len != '0) begin
            adr_d   = base_adr;
            rem_d   = len;
            state_d = ST_REQ;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_REQ: begin
        cyc = 1'b1;
        if (abort) abt_d = 1'b1;
        if (rambus_wb_ack_i) begin
          fifo_push = 1'b1;
          adr_d     = adr_q + RAMBUS_AW'(1);
          rem_d     = rem_q - RAMBUS_AW'(1);
          state_d   = ST_GAP;
        end else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
          fifo_flush = 1'b1;
          err_d      = 1'b1;
          state_d    = ST_FIN;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (abort) abt_d = 1'b1;
        if (rem_q == '0 || abort || abt_q) state_d = ST_DRAIN;
        else if (!fifo_full)               state_d = ST_REQ;
      end
      ST_DRAIN: begin
        if (abort || abt_q) begin
          fifo_flush = 1'b1;
          state_d    = ST_FIN;
        end else if (fifo_count == '0) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      abt_q   <= abt_d;
    end
  end

endmodule

// File: tb/tb_rambus_stream_reader.sv
// Directed bench for rambus_stream_reader with a 1-cycle-ack RAM model.
module tb_rambus_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [9:0]  base_adr = '0, len = '0;
  logic        busy, done, err;
  logic        wb_clk_o, wb_rst_o, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [9:0]  adr;
  logic        ack_m = 1'b0, ack_force = 1'b0, ram_en = 1'b1;
  logic [31:0] dat_m = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int n_checks = 0, n_fail = 0;
  int cycle_n = 0;

  rambus_stream_reader #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(255)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
    .base_adr(base_adr), .len(len), .busy(busy), .done(done), .err(err),
    .rambus_wb_clk_o(wb_clk_o), .rambus_wb_rst_o(wb_rst_o),
    .rambus_wb_cyc_o(cyc), .rambus_wb_stb_o(stb), .rambus_wb_we_o(we),
    .rambus_wb_sel_o(sel), .rambus_wb_dat_o(dat_o), .rambus_wb_adr_o(adr),
    .rambus_wb_ack_i(ack_m | ack_force), .rambus_wb_dat_i(dat_m),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_n++;

  function automatic logic [31:0] ram_word(input logic [9:0] a);
    return 32'hD000_0000 + ({22'b0, a} * 32'h0001_0003);
  endfunction

  // RAM model: acks one cycle after seeing a strobe, one cycle wide.
  always @(posedge clk or posedge rst) begin
    if (rst) ack_m <= 1'b0;
    else begin
      ack_m <= ram_en && cyc && stb && !ack_m;
      dat_m <= ram_word(adr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor, sampled on the falling edge.
  logic [9:0]  rd_adr[$];
  logic [31:0] got[$];
  int gaps[$];
  int done_cnt = 0, err_cnt = 0, err_alone = 0, done_cyc = 0, cyc_rises = 0;
  int low_run = 0, hi_run = 0, last_hi = 0;
  bit prev_read = 0, cyc_prev = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_read = 0; cyc_prev = 0; hi_run = 0; low_run = 0;
    end else begin
      if (prev_read) chk("ack_to_valid", {31'b0, out_valid}, 32'd1);
      prev_read = cyc && (ack_m | ack_force);
      if (prev_read) rd_adr.push_back(adr);
      if (out_valid && out_ready) got.push_back(out_data);
      if (done) begin
        done_cnt++; done_cyc = cycle_n;
        if (err) err_cnt++;
      end else if (err) err_alone++;
      if (cyc && !cyc_prev) begin
        cyc_rises++;
        if (rd_adr.size() > 0) gaps.push_back(low_run);
      end
      low_run = cyc ? 0 : low_run + 1;
      if (cyc) hi_run++;
      else begin
        if (cyc_prev) last_hi = hi_run;
        hi_run = 0;
      end
      cyc_prev = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns the cycle number start was sampled in.
  task automatic do_start(input logic [9:0] b, input logic [9:0] l, output int s_cyc);
    tick(1);
    start = 1'b1; base_adr = b; len = l; s_cyc = cycle_n;
    tick(1);
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("cyc_after_start", {31'b0, cyc}, {31'b0, (l != 10'd0)});
  endtask

  task automatic wait_done(input int budget, input int d0);
    int i;
    for (i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    #1;
    if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [9:0] base;
    logic [9:0] len;
    int         stall;
    int         stall_reads;
    bit         chk_gaps;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int s, d0, e0;
    logic [9:0] a;
    rd_adr.delete(); got.delete(); gaps.delete();
    d0 = done_cnt; e0 = err_cnt;
    out_ready = (v.stall == 0);
    do_start(v.base, v.len, s);
    if (v.stall > 0) begin
      tick(v.stall);
      chk($sformatf("v%0d_stall_reads", idx), rd_adr.size(), v.stall_reads);
      chk($sformatf("v%0d_stall_cyc", idx), {31'b0, cyc}, 32'd0);
      out_ready = 1'b1;
    end
    wait_done(2000, d0);
    chk($sformatf("v%0d_done", idx), done_cnt - d0, 32'd1);
    chk($sformatf("v%0d_err", idx), err_cnt - e0, 32'd0);
    chk($sformatf("v%0d_nreads", idx), rd_adr.size(), {22'b0, v.len});
    chk($sformatf("v%0d_nwords", idx), got.size(), {22'b0, v.len});
    for (int i = 0; i < int'(v.len) && i < rd_adr.size() && i < got.size(); i++) begin
      a = v.base + 10'(i);
      chk($sformatf("v%0d_adr%0d", idx, i), {22'b0, rd_adr[i]}, {22'b0, a});
      chk($sformatf("v%0d_dat%0d", idx, i), got[i], ram_word(a));
    end
    if (v.chk_gaps)
      foreach (gaps[i]) chk($sformatf("v%0d_gap%0d", idx, i), gaps[i], 32'd1);
    tick(1);
    chk($sformatf("v%0d_idle", idx), {30'b0, busy, out_valid}, 32'd0);
  endtask

  initial begin
    vec_t vecs[3];
    int s, d0, e0, r0, i;
    vecs[0] = '{base: 10'h010, len: 10'd3, stall: 0,  stall_reads: 0, chk_gaps: 1};
    vecs[1] = '{base: 10'h3FE, len: 10'd4, stall: 0,  stall_reads: 0, chk_gaps: 1};
    vecs[2] = '{base: 10'h120, len: 10'd8, stall: 40, stall_reads: 4, chk_gaps: 0};

    tick(3);
    chk("rst_cyc", {31'b0, cyc}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_adr", {22'b0, adr}, 32'd0);
    rst = 1'b0;
    tick(2);
    chk("idle_flags", {29'b0, done, err, busy}, 32'd0);
    chk("const_bus", {dat_o[27:0], sel, we}, {28'd0, 4'hF, 1'b0});

    for (int k = 0; k < 3; k++) run_vec(vecs[k], k);

    // RAM never answers: cyc held 255 cycles, then done+err together.
    ram_en = 1'b0; d0 = done_cnt; e0 = err_cnt; rd_adr.delete();
    do_start(10'h055, 10'd2, s);
    wait_done(400, d0);
    chk("tmo_cyc_len", last_hi, 32'd255);
    chk("tmo_done", done_cnt - d0, 32'd1);
    chk("tmo_err", err_cnt - e0, 32'd1);
    chk("tmo_err_alone", err_alone, 32'd0);
    tick(1);
    ack_force = 1'b1;
    tick(3);
    ack_force = 1'b0;
    chk("late_ack_valid", {31'b0, out_valid}, 32'd0);
    chk("late_ack_busy", {31'b0, busy}, 32'd0);
    chk("late_ack_reads", rd_adr.size(), 32'd0);
    ram_en = 1'b1;
    tick(2);

    // Abort during the second request of a 6-word run.
    rd_adr.delete(); got.delete(); out_ready = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    do_start(10'h200, 10'd6, s);
    for (i = 0; i < 50 && !(rd_adr.size() == 1 && cyc); i++) tick(1);
    chk("abort_reach_req2", {31'b0, cyc}, 32'd1);
    abort = 1'b1;
    wait_done(50, d0);
    abort = 1'b0;
    chk("abort_reads", rd_adr.size(), 32'd2);
    chk("abort_done", done_cnt - d0, 32'd1);
    chk("abort_err", err_cnt - e0, 32'd0);
    chk("abort_flushed", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick(2);
    chk("abort_words", got.size(), 32'd0);

    // Empty run: done without any bus cycle.
    d0 = done_cnt; r0 = cyc_rises;
    do_start(10'h000, 10'd0, s);
    wait_done(5, d0);
    chk("len0_lat_ok", {31'b0, (done_cyc - s >= 1 && done_cyc - s <= 2)}, 32'd1);
    tick(3);
    chk("len0_no_cyc", cyc_rises - r0, 32'd0);
    chk("len0_done_once", done_cnt - d0, 32'd1);

    // Reset in the middle of a request.
    rd_adr.delete(); out_ready = 1'b0; d0 = done_cnt;
    do_start(10'h300, 10'd5, s);
    for (i = 0; i < 50 && !(rd_adr.size() == 1 && cyc); i++) tick(1);
    chk("rst_reach_req2", {30'b0, cyc, out_valid}, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_outs", {29'b0, cyc, out_valid, busy}, 32'd0);
    tick(2);
    rst = 1'b0;
    out_ready = 1'b1;
    tick(4);
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    run_vec(vecs[0], 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
